axi_sram_slv: RTL

//  AXI3-style single-outstanding responder bridging a 32-bit AXI port to a single-port sync SRAM.

---
 rtl/axi_sram_if.sv | 72 +++++++
 rtl/axi_sram_slv.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axi_sram_if.sv
// AXI3 slave-port bundle plus the single-port SRAM macro pins used by axi_sram_slv.
// The slave modport is the bridge's view; master is the requester/memory-model side.
interface axi_sram_if #(
   parameter int MEM_AW = 14
) ();
   logic [9:0]        s_awid;
   logic [31:0]       s_awaddr;
   logic [7:0]        s_awlen;
   logic [2:0]        s_awsize;
   logic [1:0]        s_awburst;
   logic              s_awvalid;
   logic              s_awready;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic [9:0]        s_wid;
   logic              s_wlast;
   logic              s_wvalid;
   logic              s_wready;
   logic [9:0]        s_bid;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;
   logic [9:0]        s_arid;
   logic [31:0]       s_araddr;
   logic [7:0]        s_arlen;
   logic [2:0]        s_arsize;
   logic [1:0]        s_arburst;
   logic              s_arvalid;
   logic              s_arready;
   logic [9:0]        s_rid;
   logic [31:0]       s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rlast;
   logic              s_rvalid;
   logic              s_rready;
   logic              sram_cs;
   logic              sram_we;
   logic [MEM_AW-1:0] sram_a;
   logic [3:0]        sram_byte;
   logic [31:0]       sram_di;
   logic [31:0]       sram_do;

   modport slave (
      input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
      output s_awready,
      input  s_wdata, s_wstrb, s_wid, s_wlast, s_wvalid,
      output s_wready,
      output s_bid, s_bresp, s_bvalid,
      input  s_bready,
      input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
      output s_arready,
      output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      input  s_rready,
      output sram_cs, sram_we, sram_a, sram_byte, sram_di,
      input  sram_do
   );

   modport master (
      output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
      input  s_awready,
      output s_wdata, s_wstrb, s_wid, s_wlast, s_wvalid,
      input  s_wready,
      input  s_bid, s_bresp, s_bvalid,
      output s_bready,
      output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
      input  s_arready,
      input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      output s_rready,
      input  sram_cs, sram_we, sram_a, sram_byte, sram_di,
      output sram_do
   );
endinterface

// File: rtl/axi_sram_slv.sv
// Single-outstanding AXI3 responder in front of a synchronous single-port SRAM.
// Reads take two cycles per beat (request, then data); writes go straight through per W beat.
module axi_sram_slv #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_AW    = 14
) (
   input logic       clk,
   input logic       rstn,
   axi_sram_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RDATA} state_t;

   state_t      state_reg, state_next;
   logic        rr_pri_reg, rr_pri_next;
   logic [9:0]  id_reg, id_next;
   logic [31:0] addr_reg, addr_next;
   logic [7:0]  len_reg, len_next;
   logic [7:0]  beat_cnt_reg, beat_cnt_next;
   logic [1:0]  burst_reg, burst_next;
   logic        err_reg, err_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        first_reg, first_next;

   logic        grant_w, grant_r, in_range, last_beat;
   logic [31:0] addr_step, beat_data;

   assign in_range  = (addr_reg[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
   assign addr_step = (burst_reg == 2'b00) ? addr_reg : addr_reg + 32'd4;
   assign last_beat = (beat_cnt_reg == len_reg);
   assign beat_data = in_range ? bus.sram_do : 32'd0;
   // rr_pri = 0 favours the write channel when both address channels are valid
   assign grant_w = (state_reg == IDLE) && bus.s_awvalid && (!bus.s_arvalid || !rr_pri_reg);
   assign grant_r = (state_reg == IDLE) && bus.s_arvalid && (!bus.s_awvalid || rr_pri_reg);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         rr_pri_reg   <= 1'b0;
         id_reg       <= '0;
         addr_reg     <= '0;
         len_reg      <= '0;
         beat_cnt_reg <= '0;
         burst_reg    <= '0;
         err_reg      <= 1'b0;
         rdata_reg    <= '0;
         first_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rr_pri_reg   <= rr_pri_next;
         id_reg       <= id_next;
         addr_reg     <= addr_next;
         len_reg      <= len_next;
         beat_cnt_reg <= beat_cnt_next;
         burst_reg    <= burst_next;
         err_reg      <= err_next;
         rdata_reg    <= rdata_next;
         first_reg    <= first_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rr_pri_next   = rr_pri_reg;
      id_next       = id_reg;
      addr_next     = addr_reg;
      len_next      = len_reg;
      beat_cnt_next = beat_cnt_reg;
      burst_next    = burst_reg;
      err_next      = err_reg;
      rdata_next    = rdata_reg;
      first_next    = first_reg;

      bus.s_awready = 1'b0;
      bus.s_arready = 1'b0;
      bus.s_wready  = 1'b0;
      bus.s_bvalid  = 1'b0;
      bus.s_bid     = '0;
      bus.s_bresp   = 2'b00;
      bus.s_rvalid  = 1'b0;
      bus.s_rid     = '0;
      bus.s_rresp   = 2'b00;
      bus.s_rlast   = 1'b0;
      // SRAM output is only valid in the first RDATA cycle, so it is passed through then and held after
      bus.s_rdata   = first_reg ? beat_data : rdata_reg;
      bus.sram_cs   = 1'b0;
      bus.sram_we   = 1'b0;
      bus.sram_a    = '0;
      bus.sram_byte = '0;
      bus.sram_di   = '0;

      case (state_reg)
         IDLE: begin
            bus.s_awready = grant_w;
            bus.s_arready = grant_r;
            if (grant_w) begin
               id_next       = bus.s_awid;
               addr_next     = bus.s_awaddr;
               len_next      = bus.s_awlen;
               burst_next    = bus.s_awburst;
               beat_cnt_next = '0;
               err_next      = 1'b0;
               rr_pri_next   = ~rr_pri_reg;
               state_next    = WDATA;
            end else if (grant_r) begin
               id_next       = bus.s_arid;
               addr_next     = bus.s_araddr;
               len_next      = bus.s_arlen;
               burst_next    = bus.s_arburst;
               beat_cnt_next = '0;
               rr_pri_next   = ~rr_pri_reg;
               state_next    = RREQ;
            end
         end
         WDATA: begin
            bus.s_wready = 1'b1;
            if (bus.s_wvalid) begin
               if (in_range) begin
                  if (bus.s_wstrb != 4'b0000) begin
                     bus.sram_cs   = 1'b1;
                     bus.sram_we   = 1'b1;
                     bus.sram_a    = addr_reg[MEM_AW+1:2];
                     bus.sram_byte = bus.s_wstrb;
                     bus.sram_di   = bus.s_wdata;
                  end
               end else begin
                  err_next = 1'b1;
               end
               if (bus.s_wlast != last_beat) err_next = 1'b1;
               beat_cnt_next = beat_cnt_reg + 8'd1;
               addr_next     = addr_step;
               if (bus.s_wlast) state_next = WRESP;
            end
         end
         WRESP: begin
            bus.s_bvalid = 1'b1;
            bus.s_bid    = id_reg;
            bus.s_bresp  = err_reg ? 2'b10 : 2'b00;
            if (bus.s_bready) state_next = IDLE;
         end
         RREQ: begin
            if (in_range) begin
               bus.sram_cs = 1'b1;
               bus.sram_a  = addr_reg[MEM_AW+1:2];
            end
            first_next = 1'b1;
            state_next = RDATA;
         end
         RDATA: begin
            bus.s_rvalid = 1'b1;
            bus.s_rid    = id_reg;
            bus.s_rresp  = in_range ? 2'b00 : 2'b10;
            bus.s_rlast  = last_beat;
            if (first_reg) begin
               rdata_next = beat_data;
               first_next = 1'b0;
            end
            if (bus.s_rready) begin
               if (last_beat) begin
                  state_next = IDLE;
               end else begin
                  beat_cnt_next = beat_cnt_reg + 8'd1;
                  addr_next     = addr_step;
                  state_next    = RREQ;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule
